// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial A-B controller, LSB first, one bit per clock
// Two chained half-subtractor stages fed from operand shift registers and a borrow register.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic d1, b1, dbit, b2;

  always_comb begin
    d1   = a_q[0] ^ b_q[0];
    b1   = ~a_q[0] & b_q[0];
    dbit = d1 ^ br_q;
    b2   = ~d1 & br_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        br_d  = b1 | b2;
        res_d = {dbit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = b1 | b2;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed and random checks of serial_sub_ctrl at WIDTH 8 and 32
module tb_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start32, busy32, done32, bout32;
  logic [31:0] a32, b32, diff32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .diff(diff32), .bout(bout32)
  );

  // Called at a negedge; returns at the negedge where done is seen (or after a 40-cycle bound).
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, output logic [7:0] dv,
                      output logic bo, output int lat, output int bcnt, output bit ovl);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    ovl = busy8 && done8;
    dv  = diff8;
    bo  = bout8;
  endtask

  task automatic run32(input logic [31:0] av, input logic [31:0] bv, output logic [31:0] dv,
                       output logic bo, output int lat);
    start32 = 1'b1; a32 = av; b32 = bv;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 0;
    while (!done32 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    dv = diff32;
    bo = bout32;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start32 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; a32 = '1; b32 = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      n_bad++; $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    end
    n_cmp++;
    if ({busy32, done32, diff32, bout32} !== 35'd0) begin
      n_bad++; $display("FAIL reset32: got busy=%b done=%b diff=%h bout=%b, want all 0", busy32, done32, diff32, bout32);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] dv; logic bo; int lat, bcnt; bit ovl;
    run8(8'h5A, 8'h1C, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (lat !== 8 || bcnt !== 8 || ovl) begin
      n_bad++; $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d overlap=%0b, want 8 8 0", lat, bcnt, ovl);
    end
    n_cmp++;
    if (dv !== 8'h3E || bo !== 1'b0) begin
      n_bad++; $display("FAIL basic_result: got diff=%h bout=%b, want 3e 0", dv, bo);
    end
    @(negedge clk);
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_bad++; $display("FAIL basic_done_pulse: got done=%b busy=%b one cycle later, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] dv; logic bo; int lat, bcnt; bit ovl;
    run8(8'h10, 8'h20, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (dv !== 8'hF0 || bo !== 1'b1) begin
      n_bad++; $display("FAIL borrow_10_20: got diff=%h bout=%b, want f0 1", dv, bo);
    end
    @(negedge clk);
    run8(8'h00, 8'h01, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (dv !== 8'hFF || bo !== 1'b1 || lat !== 8) begin
      n_bad++; $display("FAIL borrow_ripple: got diff=%h bout=%b lat=%0d, want ff 1 8", dv, bo, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [7:0] dv; logic bo; int lat, bcnt; bit ovl;
    run8(8'hFF, 8'hFF, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (dv !== 8'h00 || bo !== 1'b0) begin
      n_bad++; $display("FAIL equal_ops: got diff=%h bout=%b, want 00 0", dv, bo);
    end
    a8 = 8'h77; b8 = 8'h99;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (diff8 !== 8'h00 || bout8 !== 1'b0 || busy8 !== 1'b0) begin
      n_bad++; $display("FAIL hold_idle: got diff=%h bout=%b busy=%b, want 00 0 0", diff8, bout8, busy8);
    end
    run8(8'hFF, 8'h00, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (dv !== 8'hFF || bo !== 1'b0) begin
      n_bad++; $display("FAIL ff_minus_0: got diff=%h bout=%b, want ff 0", dv, bo);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc = 0, ndone = 0, nbusy_after = 0;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done8) ndone++;
    n_cmp++;
    if (diff8 !== 8'h7F || bout8 !== 1'b0) begin
      n_bad++; $display("FAIL ignore_result: got diff=%h bout=%b, want 7f 0", diff8, bout8);
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) begin
      if (done8) ndone++;
      if (busy8) nbusy_after++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone !== 1 || nbusy_after !== 0) begin
      n_bad++; $display("FAIL ignore_start: got done_pulses=%0d busy_after=%0d, want 1 0", ndone, nbusy_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] dv; logic bo; int lat, bcnt; bit ovl;
    int ndone = 0;
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h1C;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy: got busy=%b before reset, want 1", busy8);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++; $display("FAIL reset_no_done: got %0d done pulses, want 0", ndone);
    end
    run8(8'h03, 8'h05, dv, bo, lat, bcnt, ovl);
    n_cmp++;
    if (dv !== 8'hFE || bo !== 1'b1 || lat !== 8) begin
      n_bad++; $display("FAIL after_reset: got diff=%h bout=%b lat=%0d, want fe 1 8", dv, bo, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t[3];
    int nd = 0, cyc = 0;
    bit ovl = 0;
    start8 = 1'b1; a8 = 8'h30; b8 = 8'h10;
    while (nd < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (busy8 && done8) ovl = 1;
      if (done8) begin
        t[nd] = cyc;
        nd++;
        if (nd == 3) start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    n_cmp++;
    if (nd !== 3 || ovl) begin
      n_bad++; $display("FAIL b2b_count: got %0d done pulses overlap=%0b, want 3 0", nd, ovl);
    end else begin
      n_cmp++;
      if (t[1] - t[0] !== 10 || t[2] - t[1] !== 10) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d and %0d cycles, want 10 and 10", t[1] - t[0], t[2] - t[1]);
      end
    end
    n_cmp++;
    if (diff8 !== 8'h20 || bout8 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_result: got diff=%h bout=%b, want 20 0", diff8, bout8);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random8();
    logic [7:0] av, bv, dv, ed; logic bo; int lat, bcnt; bit ovl;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      ed = av - bv;
      run8(av, bv, dv, bo, lat, bcnt, ovl);
      n_cmp++;
      if (dv !== ed || bo !== (av < bv) || lat !== 8 || ovl) begin
        n_bad++; $display("FAIL rand8 %h-%h: got diff=%h bout=%b lat=%0d, want %h %b 8", av, bv, dv, bo, lat, ed, av < bv);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random32();
    logic [31:0] av, bv, dv, ed; logic bo; int lat;
    for (int i = 0; i < 1000; i++) begin
      av = $urandom; bv = $urandom;
      if (i == 0) begin av = 32'h0; bv = 32'h1; end
      ed = av - bv;
      run32(av, bv, dv, bo, lat);
      n_cmp++;
      if (dv !== ed || bo !== (av < bv) || lat !== 32) begin
        n_bad++; $display("FAIL rand32 %h-%h: got diff=%h bout=%b lat=%0d, want %h %b 32", av, bv, dv, bo, lat, ed, av < bv);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_borrow();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_random32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
